// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register target.
// Holds the FSM state encoding and bus-level constants.
// No logic; imported by the target top.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_tgt_state_e;

  localparam logic I2C_ACK           = 1'b0;
  localparam logic I2C_NACK          = 1'b1;
  localparam int   I2C_BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA and derives SCL edges plus START/STOP conditions.
// Latency: SYNC_STAGES+1 clk from pin edge to registered event pulse.
// No backpressure: pulses are single-cycle and must be consumed immediately.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;
  logic                   w_start;
  logic                   w_stop;

  assign w_scl   = r_scl_sync[SYNC_STAGES-1];
  assign w_sda   = r_sda_sync[SYNC_STAGES-1];
  // SCL must be high on both samples so an SCL edge is never mistaken for START/STOP
  assign w_start = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop  = w_scl & r_scl_prev & ~r_sda_prev & w_sda & ~w_start;

  // Synchroniser chain and registered edge/condition pulses; lines idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
      scl_rise   <= 1'b0;
      scl_fall   <= 1'b0;
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      sda_s      <= 1'b1;
    end else begin
      r_scl_sync <= SYNC_STAGES'({r_scl_sync, scl_i});
      r_sda_sync <= SYNC_STAGES'({r_sda_sync, sda_i});
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      scl_rise   <= w_scl & ~r_scl_prev;
      scl_fall   <= ~w_scl & r_scl_prev;
      start_det  <= w_start;
      stop_det   <= w_stop;
      sda_s      <= w_sda;
    end
  end

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a small byte register file and auto-incrementing pointer.
// Latency: bits sampled SYNC_STAGES+1 clk after SCL rise; SDA driven one clk after the SCL-fall event.
// No clock stretching: the target never holds the bus, it only ACKs/NACKs.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h20,
  parameter int         NUM_REGS    = 4,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          PRESETn,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic [7:0]    saved_data,
  output logic          wr_valid,
  output logic          busy,
  output logic [PW-1:0] reg_ptr
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [2:0]    LAST_BIT = 3'(I2C_BITS_PER_BYTE - 1);

  logic           w_scl_rise;
  logic           w_scl_fall;
  logic           w_start;
  logic           w_stop;
  logic           w_sda_s;
  logic [7:0]     w_byte;
  logic [7:0]     w_rd_byte;
  logic           w_rd_bit;
  logic           w_last_bit;
  logic           w_addr_hit;

  i2c_tgt_state_e r_state;
  logic [2:0]     r_bit_cnt;
  logic [6:0]     r_shift;
  logic           r_rw;
  logic           r_fall_d;
  logic           r_sda_oe;
  logic [7:0]     r_saved;
  logic           r_wr_valid;
  logic           r_busy;
  logic [PW-1:0]  r_reg_ptr;
  logic [7:0]     r_regs [NUM_REGS];

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk      (clk),
    .rst_n    (PRESETn),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start_det(w_start),
    .stop_det (w_stop),
    .sda_s    (w_sda_s)
  );

  // The 7 previously shifted bits plus the bit on the line form the complete byte
  assign w_byte     = {r_shift, w_sda_s};
  assign w_rd_byte  = r_regs[r_reg_ptr];
  assign w_rd_bit   = w_rd_byte[3'd7 - r_bit_cnt];
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  // General call (address 0) is never acknowledged
  assign w_addr_hit = (r_shift == TARGET_ADDR) && (r_shift != 7'd0);

  assign sda_oe     = r_sda_oe;
  assign saved_data = r_saved;
  assign wr_valid   = r_wr_valid;
  assign busy       = r_busy;
  assign reg_ptr    = r_reg_ptr;

  // Protocol FSM: bus conditions first, then bit sampling on SCL rise, then SDA drive after SCL fall
  always_ff @(posedge clk or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 7'd0;
      r_rw       <= 1'b0;
      r_fall_d   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_saved    <= 8'h00;
      r_wr_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_reg_ptr  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else begin
      r_wr_valid <= 1'b0;
      r_fall_d   <= w_scl_fall;
      if (w_start) begin
        // Repeated START keeps the pointer so a pointer write can precede a read
        r_state   <= ST_ADDR;
        r_bit_cnt <= 3'd0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        if (w_scl_rise) begin
          case (r_state)
            ST_ADDR: begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                if (w_addr_hit) begin
                  r_state <= ST_ADDR_ACK;
                  r_rw    <= w_sda_s;
                  r_busy  <= 1'b1;
                end else begin
                  r_state <= ST_WAIT_STOP;
                end
              end
            end
            ST_ADDR_ACK: begin
              r_bit_cnt <= 3'd0;
              r_state   <= r_rw ? ST_RD_DATA : ST_PTR;
            end
            ST_PTR: begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_reg_ptr <= w_byte[PW-1:0];
                r_state   <= ST_PTR_ACK;
              end
            end
            ST_PTR_ACK, ST_WR_ACK: begin
              r_bit_cnt <= 3'd0;
              r_state   <= ST_WR_DATA;
            end
            ST_WR_DATA: begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_regs[r_reg_ptr] <= w_byte;
                r_saved           <= w_byte;
                r_wr_valid        <= 1'b1;
                r_reg_ptr         <= r_reg_ptr + PTR_ONE;
                r_state           <= ST_WR_ACK;
              end
            end
            ST_RD_DATA: begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_reg_ptr <= r_reg_ptr + PTR_ONE;
                r_state   <= ST_RD_ACK;
              end
            end
            ST_RD_ACK: begin
              r_bit_cnt <= 3'd0;
              r_state   <= (w_sda_s == I2C_ACK) ? ST_RD_DATA : ST_WAIT_STOP;
            end
            default: ;
          endcase
        end
        // SDA only changes one clk after the SCL-fall event, giving hold time on the line
        if (r_fall_d) begin
          case (r_state)
            ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: r_sda_oe <= ~I2C_ACK;
            ST_RD_DATA:                         r_sda_oe <= ~w_rd_bit;
            default:                            r_sda_oe <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Bus-level controller model drives SCL/SDA; a reference register file predicts writes and read data.
// Expected writes/reads are queued at issue time; a monitor compares them as the DUT presents them.
module tb_i2c_target_regs;

  localparam int  NREG = 4;
  localparam time Q    = 320;  // quarter SCL period (8 clk at 25 MHz)

  logic       clk = 1'b0;
  logic       PRESETn = 1'b0;
  logic       scl_ctl = 1'b1;
  logic       sda_ctl = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] saved_data;
  logic       wr_valid;
  logic       busy;
  logic [1:0] reg_ptr;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [NREG];
  int         mptr;
  logic [7:0] wr_exp [$];
  logic [7:0] rd_exp [$];
  logic [7:0] rd_obs [$];

  assign sda_line = sda_ctl & ~sda_oe;

  always #20 clk = ~clk;

  i2c_target_regs #(
    .TARGET_ADDR(7'h20),
    .NUM_REGS   (NREG),
    .SYNC_STAGES(2)
  ) dut (
    .clk       (clk),
    .PRESETn   (PRESETn),
    .scl_i     (scl_ctl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .saved_data(saved_data),
    .wr_valid  (wr_valid),
    .busy      (busy),
    .reg_ptr   (reg_ptr)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor: compare DUT-presented writes and controller-observed read bytes against queued expectations
  always @(negedge clk) begin
    if (PRESETn) begin
      if (wr_valid) begin
        if (wr_exp.size() == 0) chk("unexpected_wr_valid", 1, 0);
        else chk("wr_data", saved_data, wr_exp.pop_front());
      end
      if (rd_obs.size() > 0) begin
        if (rd_exp.size() == 0) chk("unexpected_rd_byte", 1, 0);
        else chk("rd_data", rd_obs.pop_front(), rd_exp.pop_front());
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic i2c_start();
    sda_ctl = 1'b1; #Q;
    scl_ctl = 1'b1; #Q;
    sda_ctl = 1'b0; #Q;
    scl_ctl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_ctl = 1'b0; #Q;
    scl_ctl = 1'b1; #Q;
    sda_ctl = 1'b1; #Q;
  endtask

  task automatic bit_x(input logic b, output logic obs);
    sda_ctl = b;    #Q;
    scl_ctl = 1'b1; #Q;
    obs = sda_line; #Q;
    scl_ctl = 1'b0; #Q;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic acked);
    logic o;
    for (int i = 7; i >= 0; i--) bit_x(d[i], o);
    bit_x(1'b1, o);
    acked = ~o;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic o;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, o);
      d[i] = o;
    end
    bit_x(nack, o);
  endtask

  task automatic idle_chk();
    repeat (8) @(posedge clk);
    #1;
    chk("busy_after_stop", busy, 0);
    chk("sda_oe_after_stop", sda_oe, 0);
    chk("reg_ptr_after_stop", reg_ptr, mptr);
  endtask

  task automatic write_txn(input logic [7:0] p, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic       a;
    logic [7:0] d [3];
    d = '{d0, d1, d2};
    i2c_start();
    wbyte(8'h40, a);
    chk("addr_w_ack", a, 1);
    chk("busy_on_match", busy, 1);
    wbyte(p, a);
    chk("ptr_ack", a, 1);
    mptr = p % NREG;
    for (int i = 0; i < n; i++) begin
      wr_exp.push_back(d[i]);
      mem[mptr] = d[i];
      mptr = (mptr + 1) % NREG;
      wbyte(d[i], a);
      chk("data_ack", a, 1);
    end
    i2c_stop();
    idle_chk();
  endtask

  task automatic read_txn(input logic set_ptr, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      wbyte(8'h40, a);
      chk("addr_w_ack", a, 1);
      wbyte(p, a);
      chk("ptr_ack", a, 1);
      mptr = p % NREG;
      i2c_start();
    end
    wbyte(8'h41, a);
    chk("addr_r_ack", a, 1);
    chk("busy_on_match", busy, 1);
    for (int i = 0; i < n; i++) begin
      rd_exp.push_back(mem[mptr]);
      mptr = (mptr + 1) % NREG;
      rbyte(i == n - 1, d);
      rd_obs.push_back(d);
    end
    chk("sda_released_after_nack", sda_oe, 0);
    i2c_stop();
    idle_chk();
  endtask

  task automatic bad_txn(input logic [6:0] ad, input logic rw);
    logic a;
    i2c_start();
    wbyte({ad, rw}, a);
    chk("bad_addr_nack", a, 0);
    chk("busy_no_match", busy, 0);
    i2c_stop();
    idle_chk();
  endtask

  initial begin
    logic       a;
    logic       o;
    logic       found;
    logic [6:0] ad;
    int         kind;
    for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
    mptr = 0;

    #1;
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_saved_data", saved_data, 0);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_ptr", reg_ptr, 0);
    repeat (4) @(negedge clk);
    PRESETn = 1'b1;
    repeat (4) @(negedge clk);

    // Plain write, auto-increment with wrap, combined read of the wrapped pair
    write_txn(8'h01, 1, 8'hA5, 8'h00, 8'h00);
    write_txn(8'h03, 2, 8'h11, 8'h22, 8'h00);
    read_txn(1'b1, 8'h03, 2);
    bad_txn(7'h29, 1'b0);      // 0x52 on the wire
    bad_txn(7'h00, 1'b0);      // general call

    // Abort: pointer 2, then STOP after 5 data bits of 1
    i2c_start();
    wbyte(8'h40, a);
    chk("abort_addr_ack", a, 1);
    wbyte(8'h02, a);
    chk("abort_ptr_ack", a, 1);
    mptr = 2;
    for (int i = 0; i < 5; i++) bit_x(1'b1, o);
    i2c_stop();
    idle_chk();
    read_txn(1'b0, 8'h00, 1);  // current-address read of reg 2 must still hold its old value

    // Reset while the target drives a 0 data bit
    write_txn(8'h00, 1, 8'h3C, 8'h00, 8'h00);
    i2c_start();
    wbyte(8'h40, a);
    wbyte(8'h00, a);
    i2c_start();
    wbyte(8'h41, a);
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found) begin
        sda_ctl = 1'b1; #Q;
        if (sda_oe) begin
          PRESETn = 1'b0;
          #1;
          chk("rst_mid_sda_oe", sda_oe, 0);
          found = 1'b1;
        end else begin
          scl_ctl = 1'b1; #(2*Q);
          scl_ctl = 1'b0; #Q;
        end
      end
    end
    chk("rst_mid_driving_seen", found, 1);
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_saved", saved_data, 0);
    chk("rst_mid_ptr", reg_ptr, 0);
    chk("rst_mid_wr_valid", wr_valid, 0);
    for (int i = 0; i < NREG; i++) mem[i] = 8'h00;
    mptr = 0;
    repeat (3) @(negedge clk);
    PRESETn = 1'b1;
    repeat (3) @(negedge clk);
    i2c_stop();
    idle_chk();

    // Randomised traffic against the reference register file
    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: write_txn(8'($urandom_range(0, 255)), $urandom_range(1, 3),
                     8'($urandom), 8'($urandom), 8'($urandom));
        1: read_txn(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 3));
        2: read_txn(1'b0, 8'h00, $urandom_range(1, 3));
        default: begin
          ad = 7'($urandom_range(0, 127));
          if (ad == 7'h20) ad = 7'h21;
          bad_txn(ad, 1'($urandom));
        end
      endcase
    end

    repeat (10) @(negedge clk);
    chk("wr_exp_drained", wr_exp.size(), 0);
    chk("rd_exp_drained", rd_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
